// File: rtl/lift_clkgen_pkg.sv
// Shared constants and types for the lift clock/tick generator.
package lift_clkgen_pkg;

  localparam int unsigned NCH_MAX     = 16;
  localparam int unsigned DIV_W       = 32;
  localparam int unsigned DEFAULT_DIV = 20000000;

  typedef logic [DIV_W-1:0] div_t;

endpackage

// File: rtl/lift_clkgen_ch.sv
// One tick/square-wave channel: period counter, one-deep divisor update slot,
// registered tick and clk_out.
module lift_clkgen_ch
  import lift_clkgen_pkg::*;
#(
  parameter int unsigned   DW       = DIV_W,
  parameter logic [DW-1:0] INIT_DIV = DW'(DEFAULT_DIV)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          sync,
  input  logic          wr,
  input  logic [DW-1:0] wr_div,
  output logic          tick,
  output logic          clk_out,
  output logic          pending
);

  logic [DW-1:0] div_q;
  logic [DW-1:0] nxt_q;
  logic [DW-1:0] cnt_q;

  logic [DW-1:0] cnt_cur;
  logic [DW-1:0] div_cur;
  logic [DW-1:0] half;
  logic          sync_apply;
  logic          run;
  logic          wrap;

  logic [DW-1:0] cnt_d;
  logic [DW-1:0] div_d;
  logic [DW-1:0] nxt_d;
  logic          tick_d;
  logic          clk_d;
  logic          pend_d;

  // A sync pulse restarts the period from zero with any pending divisor applied.
  always_comb begin
    cnt_d      = '0;
    div_d      = div_q;
    nxt_d      = nxt_q;
    tick_d     = 1'b0;
    clk_d      = 1'b0;
    pend_d     = pending;

    cnt_cur    = sync ? '0 : cnt_q;
    sync_apply = sync & pending;
    div_cur    = sync_apply ? nxt_q : div_q;
    run        = en & (div_cur != '0);
    half       = (div_cur >> 1) + DW'(div_cur[0]);
    wrap       = run & (cnt_cur == (div_cur - DW'(1)));

    if (run) begin
      tick_d = (cnt_cur == '0);
      clk_d  = (cnt_cur < half);
      cnt_d  = wrap ? '0 : (cnt_cur + DW'(1));
    end

    // Stopped channels take the new divisor at once; running ones at the wrap.
    if (sync_apply || (pending && (!run || wrap))) begin
      div_d  = nxt_q;
      pend_d = 1'b0;
    end

    if (wr) begin
      nxt_d  = wr_div;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= INIT_DIV;
      nxt_q   <= '0;
      cnt_q   <= '0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
      pending <= 1'b0;
    end else begin
      div_q   <= div_d;
      nxt_q   <= nxt_d;
      cnt_q   <= cnt_d;
      tick    <= tick_d;
      clk_out <= clk_d;
      pending <= pend_d;
    end
  end

endmodule

// File: rtl/lift_clkgen.sv
// Multi-channel programmable tick/clock generator with divisor write port.
// Optional LIFT_CLKGEN_SYNC_EN adds the sync_i realign input.
module lift_clkgen #(
  parameter int unsigned   NCH         = 4,
  parameter int unsigned   DW          = lift_clkgen_pkg::DIV_W,
  parameter logic [DW-1:0] DEFAULT_DIV = DW'(lift_clkgen_pkg::DEFAULT_DIV),
  localparam int unsigned  CW          = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk_100MHz,
  input  logic           rst,
  input  logic [NCH-1:0] ch_en,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [DW-1:0]  cfg_div,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] pending
`ifdef LIFT_CLKGEN_SYNC_EN
  ,
  input  logic           sync_i
`endif
);

  import lift_clkgen_pkg::*;

  if ((NCH < 1) || (NCH > NCH_MAX)) begin : g_bad_nch
    $error("lift_clkgen: NCH out of range");
  end

  logic           sync;
  logic           accept;
  logic [NCH-1:0] wr;

`ifdef LIFT_CLKGEN_SYNC_EN
  assign sync = sync_i;
`else
  assign sync = 1'b0;
`endif

  // Out-of-range channel numbers are always ready and simply dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (cfg_ch == CW'(i)) begin
        cfg_ready = ~pending[i];
      end
    end
  end

  assign accept = cfg_valid & cfg_ready;

  always_comb begin
    wr = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      wr[i] = accept & (cfg_ch == CW'(i));
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    lift_clkgen_ch #(
      .DW       (DW),
      .INIT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk     (clk_100MHz),
      .rst     (rst),
      .en      (ch_en[g]),
      .sync    (sync),
      .wr      (wr[g]),
      .wr_div  (cfg_div),
      .tick    (tick[g]),
      .clk_out (clk_out[g]),
      .pending (pending[g])
    );
  end

endmodule
